// File: rtl/car_sensor_gen.sv
// Car passage emulator: drives outer/inner photo-sensor outputs (a, b) through
// a three-phase enter/exit pattern, with abort and a completed-passage counter.
module car_sensor_gen #(
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               abort,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [CNT_W-1:0]   trans_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    PH3  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             next_ph_s;
  logic               dir_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [DWELL_W-1:0] cnt_r;

  // Sensor pattern {a,b} for a phase; exit mirrors enter in PH1/PH3.
  function automatic logic [1:0] pattern(input state_t st, input logic d);
    logic [1:0] p;
    case (st)
      PH1:     p = d ? 2'b01 : 2'b10;
      PH2:     p = 2'b11;
      PH3:     p = d ? 2'b10 : 2'b01;
      default: p = 2'b00;
    endcase
    return p;
  endfunction

  // Phase that follows the current one when its dwell expires.
  always_comb begin
    next_ph_s = IDLE;
    case (state_r)
      PH1:     next_ph_s = PH2;
      PH2:     next_ph_s = PH3;
      default: next_ph_s = IDLE;
    endcase
  end

  // Passage FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      dir_r     <= 1'b0;
      dwell_r   <= {DWELL_W{1'b0}};
      cnt_r     <= {DWELL_W{1'b0}};
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      trans_cnt <= {CNT_W{1'b0}};
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state_r)
        IDLE: begin
          // abort in IDLE suppresses start but produces no aborted pulse
          if (start && !abort) begin
            state_r  <= PH1;
            dir_r    <= dir;
            dwell_r  <= dwell;
            cnt_r    <= {DWELL_W{1'b0}};
            busy     <= 1'b1;
            {a, b}   <= pattern(PH1, dir);
          end else begin
            state_r  <= IDLE;
            busy     <= 1'b0;
            {a, b}   <= 2'b00;
          end
        end
        PH1, PH2, PH3: begin
          if (abort) begin
            state_r <= IDLE;
            cnt_r   <= {DWELL_W{1'b0}};
            busy    <= 1'b0;
            aborted <= 1'b1;
            {a, b}  <= 2'b00;
          end else if (cnt_r == dwell_r) begin
            cnt_r <= {DWELL_W{1'b0}};
            if (state_r == PH3) begin
              state_r   <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              trans_cnt <= trans_cnt + CNT_W'(1);
              {a, b}    <= 2'b00;
            end else begin
              state_r <= next_ph_s;
              {a, b}  <= pattern(next_ph_s, dir_r);
            end
          end else begin
            cnt_r <= cnt_r + DWELL_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          {a, b}  <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_car_sensor_gen.sv
// Scoreboard bench for car_sensor_gen: a behavioural model predicts each
// cycle's outputs, pushed on drive and popped after the clock edge.
module tb_car_sensor_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, dir, abort;
  logic [7:0] dwell;
  logic       a, b, busy, done, aborted;
  logic [15:0] trans_cnt;
  logic       a2, b2, busy2, done2, aborted2;
  logic [1:0] trans_cnt2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] ab;
    logic       busy;
    logic       done;
    logic       aborted;
    int         cnt;
  } exp_t;

  exp_t sb[$];

  // model state
  logic m_busy, m_done, m_aborted, m_dir;
  int   m_pos, m_d, m_cnt;

  always #5 clk = ~clk;

  car_sensor_gen #(.DWELL_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dir(dir), .dwell(dwell),
    .abort(abort), .a(a), .b(b), .busy(busy), .done(done),
    .aborted(aborted), .trans_cnt(trans_cnt)
  );

  car_sensor_gen #(.DWELL_W(8), .CNT_W(2)) dut_w2 (
    .clk(clk), .reset_n(reset_n), .start(start), .dir(dir), .dwell(dwell),
    .abort(abort), .a(a2), .b(b2), .busy(busy2), .done(done2),
    .aborted(aborted2), .trans_cnt(trans_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_done = 1'b0; m_aborted = 1'b0; m_dir = 1'b0;
    m_pos = 0; m_d = 0; m_cnt = 0;
  endtask

  function automatic logic [1:0] model_ab();
    int ph;
    if (!m_busy) return 2'b00;
    ph = m_pos / (m_d + 1);
    if (ph == 1) return 2'b11;
    if (ph == 0) return m_dir ? 2'b01 : 2'b10;
    return m_dir ? 2'b10 : 2'b01;
  endfunction

  // advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    m_done = 1'b0;
    m_aborted = 1'b0;
    if (m_busy) begin
      if (abort) begin
        m_busy = 1'b0; m_aborted = 1'b1;
      end else if (m_pos == 3 * (m_d + 1) - 1) begin
        m_busy = 1'b0; m_done = 1'b1; m_cnt++;
      end else begin
        m_pos++;
      end
    end else if (start && !abort) begin
      m_busy = 1'b1; m_pos = 0; m_d = int'(dwell); m_dir = dir;
    end
  endtask

  task automatic step(input logic s, input logic d, input logic [7:0] dw, input logic ab);
    exp_t e;
    @(negedge clk);
    start = s; dir = d; dwell = dw; abort = ab;
    model_edge();
    e.ab = model_ab(); e.busy = m_busy; e.done = m_done;
    e.aborted = m_aborted; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("ab", {30'd0, a, b}, {30'd0, e.ab});
    check("busy", {31'd0, busy}, {31'd0, e.busy});
    check("done", {31'd0, done}, {31'd0, e.done});
    check("aborted", {31'd0, aborted}, {31'd0, e.aborted});
    check("trans_cnt", {16'd0, trans_cnt}, e.cnt & 32'hFFFF);
    check("ab_w2", {30'd0, a2, b2}, {30'd0, e.ab});
    check("trans_cnt_w2", {30'd0, trans_cnt2}, e.cnt & 32'h3);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ab"}, {30'd0, a, b}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_aborted"}, {31'd0, aborted}, 32'd0);
    check({tag, "_cnt"}, {16'd0, trans_cnt}, 32'd0);
    check({tag, "_cnt_w2"}, {30'd0, trans_cnt2}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; dir = 1'b0; dwell = 8'd0; abort = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // enter, D=0
    step(1'b1, 1'b0, 8'd0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 8'd0, 1'b0);

    // exit, D=2, with start/dir/dwell wiggling while busy
    step(1'b1, 1'b1, 8'd2, 1'b0);
    for (int i = 0; i < 11; i++) step(i < 8, i[0], 8'(i * 3), 1'b0);

    // back-to-back, start held high
    repeat (8) step(1'b1, 1'b0, 8'd0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 8'd0, 1'b0);

    // abort in the second PH2 cycle, D=3
    step(1'b1, 1'b0, 8'd3, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'd0, m_busy && m_pos == 5);
    // abort together with start in IDLE
    step(1'b1, 1'b0, 8'd0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b0);

    // abort in the final PH3 cycle, D=1
    step(1'b1, 1'b1, 8'd1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'd0, m_busy && m_pos == 5);

    // random traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(2, 0) == 0, 1'($urandom), 8'($urandom_range(3, 0)),
           $urandom_range(11, 0) == 0);
    repeat (15) step(1'b0, 1'b0, 8'd0, 1'b0);

    // reset in the middle of PH2
    step(1'b1, 1'b0, 8'd3, 1'b0);
    while (m_pos != 5) step(1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    check_zero("held_reset");
    reset_n = 1'b1;
    step(1'b1, 1'b1, 8'd0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 8'd0, 1'b0);

    // five completed passages to wrap the 2-bit counter
    for (int p = 0; p < 5; p++) begin
      step(1'b1, 1'($urandom), 8'd0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 8'd0, 1'b0);
    end
    check("final_cnt_w2", {30'd0, trans_cnt2}, (m_cnt & 32'h3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/car_sensor_gen.md
CAR_SENSOR_GEN -- requirements
Module: car_sensor_gen

Interface
REQ-001 Parameter DWELL_W, default 8, is the width of the dwell input and the internal dwell counter.
REQ-002 Parameter CNT_W, default 16, is the width of the completed-transaction counter.
REQ-003 Port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: request to emulate one car passage; sampled only in IDLE.
REQ-006 Port dir, input, 1 bit: passage direction, sampled with start; 0 = enter, 1 = exit.
REQ-007 Port dwell, input, DWELL_W bits: per-phase hold count D, sampled with start.
REQ-008 Port abort, input, 1 bit: cancels an in-progress passage.
REQ-009 Port a, output, 1 bit: outer photo-sensor emulation, registered.
REQ-010 Port b, output, 1 bit: inner photo-sensor emulation, registered.
REQ-011 Port busy, output, 1 bit: high while a passage is in progress.
REQ-012 Port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-013 Port aborted, output, 1 bit: one-cycle pulse on abort.
REQ-014 Port trans_cnt, output, CNT_W bits: count of completed passages.

Function
REQ-015 The FSM SHALL have states IDLE, PH1, PH2 and PH3; all outputs are registered, with no combinational path from any input to any output.
REQ-016 Sensor patterns {a,b} SHALL be: IDLE 00; enter PH1/PH2/PH3 = 10/11/01; exit PH1/PH2/PH3 = 01/11/10.
REQ-017 In IDLE, start=1 and abort=0 at edge N SHALL latch dir and D, and set state PH1 with busy=1 after edge N.
REQ-018 Each of PH1, PH2 and PH3 SHALL hold for exactly D+1 cycles; D=0 gives 1 cycle per phase.
REQ-019 Total busy time SHALL be exactly 3*(D+1) cycles.
REQ-020 After the last PH3 cycle, the next edge SHALL return to IDLE with {a,b}=00, busy=0 and done=1 for exactly one cycle, and SHALL increment trans_cnt.
REQ-021 trans_cnt SHALL wrap from 2^CNT_W-1 to 0 with no saturation or flag.
REQ-022 start while busy=1 SHALL be ignored, with no queuing.
REQ-023 Changes on dir and dwell while busy=1 SHALL have no effect.
REQ-024 start=1 in the same cycle that done=1 (state IDLE) SHALL be accepted normally, giving back-to-back passages with exactly one cycle of {a,b}=00 between them.
REQ-025 abort=1 in any PH state SHALL, at the next edge, force IDLE with {a,b}=00, busy=0, done=0 and aborted=1 for one cycle; trans_cnt SHALL be unchanged.
REQ-026 abort SHALL take priority over completion: abort in the final PH3 cycle yields aborted, not done.
REQ-027 abort in IDLE SHALL have priority over start: the passage is not started and aborted stays 0.
REQ-028 The generated sequence SHALL never change a and b on the same edge except on the return to 00 after an abort from PH2.

Reset
REQ-029 reset_n=0 SHALL asynchronously force IDLE with a=0, b=0, busy=0, done=0, aborted=0, trans_cnt=0 and the dwell counter =0.
REQ-030 Reset asserted mid-passage SHALL discard that passage with no done or aborted pulse.
REQ-031 After reset_n rises, the first start SHALL be accepted no earlier than the first rising edge on which reset_n=1.

Verification
REQ-032 Enter, D=0: start=1, dir=0 for one cycle -> {a,b} = 10,11,01 for one cycle each, then 00 with done=1; busy high for 3 cycles; trans_cnt=1.
REQ-033 Exit, D=2: start with dir=1 -> {a,b} = 01,11,10 for 3 cycles each; done on cycle 10 after acceptance; trans_cnt increments by 1.
REQ-034 Back-to-back: start held high, D=0 -> enter sequence, one 00 cycle with done=1, then a second sequence; trans_cnt=2 after 8 cycles.
REQ-035 Abort: D=3, abort pulsed in the 2nd PH2 cycle -> next cycle {a,b}=00, aborted=1, done=0, trans_cnt unchanged; abort+start together in IDLE -> nothing starts.
REQ-036 Reset mid-PH2 -> a=b=busy=0 immediately and trans_cnt=0; with CNT_W=2, five completed passages -> trans_cnt=1.
